// File: rtl/tft_pattern_gen_pkg.sv
// Shared RGB565 field widths, pattern mode encodings and the colour-bar palette
// for the TFT test-pattern generator.
package tft_pattern_gen_pkg;

    localparam int R_W     = 5;
    localparam int G_W     = 6;
    localparam int B_W     = 5;
    localparam int COORD_W = 10;

    localparam logic [COORD_W-1:0] BAR_WIDTH = 10'd60;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_MOVING   = 2'd3
    } mode_e;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb_t;

    localparam rgb_t RGB_WHITE   = {5'd31, 6'd63, 5'd31};
    localparam rgb_t RGB_YELLOW  = {5'd31, 6'd63, 5'd0};
    localparam rgb_t RGB_CYAN    = {5'd0,  6'd63, 5'd31};
    localparam rgb_t RGB_GREEN   = {5'd0,  6'd63, 5'd0};
    localparam rgb_t RGB_MAGENTA = {5'd31, 6'd0,  5'd31};
    localparam rgb_t RGB_RED     = {5'd31, 6'd0,  5'd0};
    localparam rgb_t RGB_BLUE    = {5'd0,  6'd0,  5'd31};
    localparam rgb_t RGB_BLACK   = {5'd0,  6'd0,  5'd0};

    function automatic rgb_t bar_color(input logic [2:0] bar);
        rgb_t c;
        case (bar)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            3'd7:    c = RGB_BLACK;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tft_pattern_color.sv
// Combinational pattern lookup: pixel position, pattern mode and frame count to RGB565.
module tft_pattern_color
    import tft_pattern_gen_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [1:0]         mode,
    input  logic [4:0]         frame_cnt,
    output logic [R_W-1:0]     r,
    output logic [G_W-1:0]     g,
    output logic [B_W-1:0]     b
);

    rgb_t               c_s;
    logic [COORD_W-1:0] bar_s;
    logic               unused_y_bits_s;

    assign unused_y_bits_s = &{1'b0, y[COORD_W-1], y[3:0]};

    // Pick the colour for the active pattern at this position.
    always_comb begin
        c_s   = RGB_BLACK;
        bar_s = x / BAR_WIDTH;
        case (mode)
            MODE_BARS: begin
                if (bar_s > 10'd7) c_s = RGB_BLACK;
                else               c_s = bar_color(bar_s[2:0]);
            end
            MODE_CHECKER: begin
                if (x[4] ^ y[4]) c_s = RGB_WHITE;
                else             c_s = RGB_BLACK;
            end
            MODE_GRADIENT: c_s = {x[8:4], x[8:3], y[8:4]};
            MODE_MOVING: begin
                if (x[8:4] == frame_cnt) c_s = RGB_WHITE;
                else                     c_s = RGB_BLUE;
            end
            default: c_s = RGB_BLACK;
        endcase
    end

    assign r = c_s.r;
    assign g = c_s.g;
    assign b = c_s.b;

endmodule

// File: rtl/tft_pattern_gen.sv
// TFT test-pattern generator: tracks pixel position from the timing generator's
// enable/sync stream and emits an RGB565 pattern two cycles behind the inputs.
module tft_pattern_gen
    import tft_pattern_gen_pkg::*;
#(
    parameter int   H_ACTIVE        = 480,
    parameter int   V_ACTIVE        = 272,
    parameter logic SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic           in_9mhz_clk,
    input  logic           in_rst,
    input  logic           in_en,
    input  logic           in_hsync,
    input  logic           in_vsync,
    input  logic [1:0]     in_mode,
    output logic           out_en,
    output logic           out_hsync,
    output logic           out_vsync,
    output logic [R_W-1:0] out_r,
    output logic [G_W-1:0] out_g,
    output logic [B_W-1:0] out_b,
    output logic [7:0]     out_frame_cnt,
    output logic           out_overflow
);

    localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(V_ACTIVE - 1);
    localparam logic               SYNC_IDLE = SYNC_ACTIVE_LOW;

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               x_full_q, x_full_d, y_full_q, y_full_d;
    logic               en_prev_q, en_prev_d, vs_prev_q, vs_prev_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               overflow_q, overflow_d, synced_q, synced_d;
    logic [COORD_W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic [1:0]         s1_mode_q, s1_mode_d;
    logic               s1_en_q, s1_en_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic               out_en_q, out_en_d, out_hs_q, out_hs_d, out_vs_q, out_vs_d;
    rgb_t               rgb_q, rgb_d;
    logic [R_W-1:0]     col_r_s;
    logic [G_W-1:0]     col_g_s;
    logic [B_W-1:0]     col_b_s;
    logic               vs_asserted_s, vs_edge_s, en_fall_s;

    // x_full/y_full remember that the last legal position was reached, so a
    // further pixel (not the last legal one) is what flags overflow.
    always_comb begin
        vs_asserted_s = (in_vsync != SYNC_ACTIVE_LOW);
        vs_edge_s     = vs_asserted_s && !vs_prev_q;
        en_fall_s     = en_prev_q && !in_en;
        x_d           = x_q;
        x_full_d      = x_full_q;
        y_d           = y_q;
        y_full_d      = y_full_q;
        mode_d        = mode_q;
        frame_cnt_d   = frame_cnt_q;
        overflow_d    = overflow_q;
        synced_d      = synced_q;
        en_prev_d     = in_en;
        vs_prev_d     = vs_asserted_s;

        if (in_en) begin
            if (x_full_q || y_full_q) overflow_d = 1'b1;
            else                      overflow_d = overflow_q;
            if (x_q == X_MAX) x_full_d = 1'b1;
            else              x_d      = x_q + 10'd1;
        end else if (en_fall_s) begin
            x_d      = 10'd0;
            x_full_d = 1'b0;
            if (y_q == Y_MAX) y_full_d = 1'b1;
            else              y_d      = y_q + 10'd1;
        end else begin
            x_d = x_q;
        end

        // Frame start overrides any same-cycle line advance.
        if (vs_edge_s) begin
            y_d         = 10'd0;
            y_full_d    = 1'b0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            mode_d      = in_mode;
            synced_d    = 1'b1;
        end else begin
            synced_d    = synced_q;
        end

        s1_x_d    = x_q;
        s1_y_d    = y_q;
        s1_mode_d = mode_q;
        s1_en_d   = in_en && synced_d;
        s1_hs_d   = in_hsync;
        s1_vs_d   = in_vsync;
    end

    tft_pattern_color u_color (
        .x         (s1_x_q),
        .y         (s1_y_q),
        .mode      (s1_mode_q),
        .frame_cnt (frame_cnt_q[4:0]),
        .r         (col_r_s),
        .g         (col_g_s),
        .b         (col_b_s)
    );

    // Stage-2 colour and sync alignment; blank whenever the pixel is not enabled.
    always_comb begin
        out_en_d = s1_en_q;
        out_hs_d = s1_hs_q;
        out_vs_d = s1_vs_q;
        if (s1_en_q) rgb_d = {col_r_s, col_g_s, col_b_s};
        else         rgb_d = RGB_BLACK;
    end

    // All state with synchronous reset; edge history keeps following the inputs.
    always_ff @(posedge in_9mhz_clk) begin
        if (in_rst) begin
            x_q         <= 10'd0;
            x_full_q    <= 1'b0;
            y_q         <= 10'd0;
            y_full_q    <= 1'b0;
            en_prev_q   <= en_prev_d;
            vs_prev_q   <= vs_prev_d;
            mode_q      <= MODE_BARS;
            frame_cnt_q <= 8'd0;
            overflow_q  <= 1'b0;
            synced_q    <= 1'b0;
            s1_x_q      <= 10'd0;
            s1_y_q      <= 10'd0;
            s1_mode_q   <= MODE_BARS;
            s1_en_q     <= 1'b0;
            s1_hs_q     <= SYNC_IDLE;
            s1_vs_q     <= SYNC_IDLE;
            out_en_q    <= 1'b0;
            out_hs_q    <= SYNC_IDLE;
            out_vs_q    <= SYNC_IDLE;
            rgb_q       <= RGB_BLACK;
        end else begin
            x_q         <= x_d;
            x_full_q    <= x_full_d;
            y_q         <= y_d;
            y_full_q    <= y_full_d;
            en_prev_q   <= en_prev_d;
            vs_prev_q   <= vs_prev_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
            synced_q    <= synced_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_mode_q   <= s1_mode_d;
            s1_en_q     <= s1_en_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            out_en_q    <= out_en_d;
            out_hs_q    <= out_hs_d;
            out_vs_q    <= out_vs_d;
            rgb_q       <= rgb_d;
        end
    end

    assign out_en        = out_en_q;
    assign out_hsync     = out_hs_q;
    assign out_vsync     = out_vs_q;
    assign out_r         = rgb_q.r;
    assign out_g         = rgb_q.g;
    assign out_b         = rgb_q.b;
    assign out_frame_cnt = frame_cnt_q;
    assign out_overflow  = overflow_q;

endmodule

// File: tb/tb_tft_pattern_gen.sv
// Self-checking bench for tft_pattern_gen: a position/frame model predicts every
// output cycle from the stimulus stream, plus literal pins on the model and DUT.
module tb_tft_pattern_gen;

    localparam int MAXC = 40000;

    typedef struct packed {
        logic       en;
        logic       hs;
        logic       vs;
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, hs = 1'b1, vs = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       o_en, o_hs, o_vs, o_ov;
    logic [4:0] o_r, o_b;
    logic [5:0] o_g;
    logic [7:0] o_fc;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    pix_t exp_pix [MAXC];
    bit   pix_ok  [MAXC];
    int   exp_fc  [MAXC];
    bit   exp_ov  [MAXC];
    bit   st_ok   [MAXC];

    // Model state: pixel index in line, lines since frame start, latched mode etc.
    int   m_x = 0, m_y = 0, m_mode = 0, m_fc = 0;
    bit   m_ov = 1'b0, m_synced = 1'b0, prev_en = 1'b0, prev_vsa = 1'b0;

    int   bar_r [8] = '{31, 31, 0, 0, 31, 31, 0, 0};
    int   bar_g [8] = '{63, 63, 63, 63, 0, 0, 0, 0};
    int   bar_b [8] = '{31, 0, 31, 0, 31, 0, 31, 0};

    tft_pattern_gen dut (
        .in_9mhz_clk   (clk),
        .in_rst        (rst),
        .in_en         (en),
        .in_hsync      (hs),
        .in_vsync      (vs),
        .in_mode       (mode),
        .out_en        (o_en),
        .out_hsync     (o_hs),
        .out_vsync     (o_vs),
        .out_r         (o_r),
        .out_g         (o_g),
        .out_b         (o_b),
        .out_frame_cnt (o_fc),
        .out_overflow  (o_ov)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] colour(input int x, input int y, input int md, input int fc);
        int r, g, b;
        case (md)
            0: begin
                r = bar_r[x / 60]; g = bar_g[x / 60]; b = bar_b[x / 60];
            end
            1: begin
                if ((((x >> 4) ^ (y >> 4)) & 1) == 1) begin r = 31; g = 63; b = 31; end
                else begin r = 0; g = 0; b = 0; end
            end
            2: begin
                r = (x >> 4) % 32; g = (x >> 3) % 64; b = (y >> 4) % 32;
            end
            default: begin
                if (((x >> 4) % 32) == (fc % 32)) begin r = 31; g = 63; b = 31; end
                else begin r = 0; g = 0; b = 31; end
            end
        endcase
        return {r[4:0], g[5:0], b[4:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    // Per-cycle comparison: pixel outputs lag inputs by 2 cycles, status by 1.
    always @(negedge clk) begin
        if (cyc >= 2 && cyc < MAXC) begin
            if (pix_ok[cyc-2]) begin
                total++;
                if ({o_en, o_hs, o_vs, o_r, o_g, o_b} !== exp_pix[cyc-2]) begin
                    bad++;
                    $display("FAIL pixel @%0d: got en=%0b hs=%0b vs=%0b rgb=%0d/%0d/%0d want en=%0b hs=%0b vs=%0b rgb=%0d/%0d/%0d",
                             cyc, o_en, o_hs, o_vs, o_r, o_g, o_b,
                             exp_pix[cyc-2].en, exp_pix[cyc-2].hs, exp_pix[cyc-2].vs,
                             exp_pix[cyc-2].r, exp_pix[cyc-2].g, exp_pix[cyc-2].b);
                end
            end
            if (st_ok[cyc-1]) begin
                check("frame_cnt", o_fc, exp_fc[cyc-1]);
                check("overflow", o_ov, exp_ov[cyc-1]);
            end
        end
    end

    task automatic drive(input bit r_i, input bit e_i, input bit h_i, input bit v_i, input logic [1:0] md_i);
        bit   vsa, vedge, efall, syn;
        int   n, px, py;
        pix_t p;
        @(posedge clk);
        #1;
        n = cyc;
        if (n >= MAXC - 2) begin
            $display("FAIL budget: cycle %0d reached limit %0d", n, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        rst = r_i; en = e_i; hs = h_i; vs = v_i; mode = md_i;
        vsa = (v_i == 1'b0);
        p   = '0;
        if (r_i) begin
            m_x = 0; m_y = 0; m_mode = 0; m_fc = 0; m_ov = 1'b0; m_synced = 1'b0;
            p = {1'b0, 1'b1, 1'b1, 16'd0};
            if (n > 0) begin
                exp_pix[n-1] = p;
                pix_ok[n-1]  = 1'b1;
            end
        end else begin
            vedge = vsa && !prev_vsa;
            efall = prev_en && !e_i;
            syn   = m_synced || vedge;
            px    = (m_x < 480) ? m_x : 479;
            py    = (m_y < 272) ? m_y : 271;
            if (e_i && (m_x >= 480 || m_y >= 272)) m_ov = 1'b1;
            if (e_i) m_x++;
            else if (efall) begin m_x = 0; m_y++; end
            if (vedge) begin m_y = 0; m_fc = (m_fc + 1) % 256; m_synced = 1'b1; end
            p.en = e_i && syn;
            p.hs = h_i;
            p.vs = v_i;
            if (p.en) {p.r, p.g, p.b} = colour(px, py, m_mode, m_fc);
            if (vedge) m_mode = int'(md_i);
        end
        prev_vsa   = vsa;
        prev_en    = e_i;
        exp_pix[n] = p;
        pix_ok[n]  = 1'b1;
        exp_fc[n]  = m_fc;
        exp_ov[n]  = m_ov;
        st_ok[n]   = 1'b1;
    endtask

    task automatic vsync_pulse(input logic [1:0] md);
        repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0, md);
        repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b1, md);
    endtask

    task automatic line(input int len, input logic [1:0] md);
        drive(1'b0, 1'b0, 1'b0, 1'b1, md);
        repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b1, md);
        repeat (len) drive(1'b0, 1'b1, 1'b1, 1'b1, md);
        drive(1'b0, 1'b0, 1'b1, 1'b1, md);
    endtask

    initial begin
        logic [1:0] md;

        check("pin_bar_white", colour(0, 0, 0, 0), {5'd31, 6'd63, 5'd31});
        check("pin_bar_yellow", colour(60, 0, 0, 0), {5'd31, 6'd63, 5'd0});
        check("pin_bar_black", colour(479, 0, 0, 0), 32'd0);
        check("pin_chk_white", colour(15, 16, 1, 0), {5'd31, 6'd63, 5'd31});
        check("pin_chk_black", colour(16, 16, 1, 0), 32'd0);
        check("pin_gradient", colour(479, 0, 2, 0), {5'd29, 6'd59, 5'd0});
        check("pin_moving_white", colour(64, 0, 3, 4), {5'd31, 6'd63, 5'd31});
        check("pin_moving_blue", colour(80, 0, 3, 4), {5'd0, 6'd0, 5'd31});

        repeat (5) drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        check("rst_en", o_en, 32'd0);
        check("rst_rgb", {o_r, o_g, o_b}, 32'd0);
        check("rst_sync", {o_hs, o_vs}, 32'd3);
        check("rst_fc", o_fc, 32'd0);
        check("rst_ov", o_ov, 32'd0);

        vsync_pulse(2'd0);
        line(480, 2'd0);
        check("line_no_ov", o_ov, 32'd0);
        line(480, 2'd1);
        vsync_pulse(2'd1);
        repeat (16) line(64, 2'd1);
        line(64, 2'd1);
        vsync_pulse(2'd2);
        line(480, 2'd2);
        vsync_pulse(2'd3);
        repeat (2) line(480, 2'd3);
        check("fc_after_4_frames", o_fc, 32'd4);

        for (int i = 0; i < 40; i++) begin
            md = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: vsync_pulse(md);
                1: repeat ($urandom_range(5, 40))
                       drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), md);
                default: line(int'($urandom_range(1, 480)), md);
            endcase
        end

        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
        vsync_pulse(2'd2);
        repeat (272) line(1, 2'd2);
        check("y_full_no_ov", o_ov, 32'd0);
        line(1, 2'd2);
        check("y_over_ov", o_ov, 32'd1);

        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
        vsync_pulse(2'd0);
        line(500, 2'd0);
        check("x_over_ov", o_ov, 32'd1);
        line(100, 2'd0);
        check("ov_sticky", o_ov, 32'd1);

        line(50, 2'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        repeat (100) drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        check("midrst_en", o_en, 32'd0);
        check("midrst_rgb", {o_r, o_g, o_b}, 32'd0);
        check("midrst_fc", o_fc, 32'd0);
        check("midrst_ov", o_ov, 32'd0);
        repeat (100) drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        vsync_pulse(2'd1);
        check("midrst_fc_after_vs", o_fc, 32'd1);
        line(480, 2'd1);

        repeat (4) drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
